result_display_driver: RTL and testbench



---
 rtl/result_display_driver_if.sv | 21 ++
 rtl/result_display_driver.sv | 174 +++++++++++++++++
 tb/tb_result_display_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_display_driver_if.sv
// ALU result bus feeding the display driver.
// The ALU drives it through master; the display driver reads it through slave.
interface result_display_driver_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] output_num;
   logic             balanceBit;
   logic             equalityBit;

   modport master (
      output output_num,
      output balanceBit,
      output equalityBit
   );

   modport slave (
      input output_num,
      input balanceBit,
      input equalityBit
   );
endinterface

// File: rtl/result_display_driver.sv
// ALU result to BCD (shift-and-add-3) and multiplexed active-low 7-seg display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the top non-zero one.
module result_display_driver #(
   parameter int WIDTH    = 32,
   parameter int DIGITS   = 10,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  Clk,
   input  logic                  reset,
   result_display_driver_if.slave alu,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  led_balance,
   output logic                  led_equal,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy
);

   localparam int CNW = $clog2(WIDTH + 1);
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      UPDATE
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    snap_num;
   logic                snap_bal;
   logic                snap_eq;
   logic [WIDTH-1:0]    shreg;
   logic [4*DIGITS-1:0] acc;
   logic [4*DIGITS-1:0] acc_adj;
   logic [CNW-1:0]      bit_cnt;
   logic                changed;

   always_comb begin
      changed = {alu.output_num, alu.balanceBit, alu.equalityBit}
                != {snap_num, snap_bal, snap_eq};
   end

   always_comb begin
      acc_adj = acc;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc[4*k +: 4] >= 4'd5)
            acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
   end

   // bcd_out and LEDs move together, only in UPDATE
   always_ff @(posedge Clk) begin
      if (reset) begin
         state       <= IDLE;
         snap_num    <= '0;
         snap_bal    <= 1'b0;
         snap_eq     <= 1'b0;
         shreg       <= '0;
         acc         <= '0;
         bit_cnt     <= '0;
         bcd_out     <= '0;
         led_balance <= 1'b0;
         led_equal   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (changed) begin
                  snap_num <= alu.output_num;
                  snap_bal <= alu.balanceBit;
                  snap_eq  <= alu.equalityBit;
                  shreg    <= alu.output_num;
                  acc      <= '0;
                  bit_cnt  <= CNW'(WIDTH);
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               acc     <= {acc_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
               shreg   <= shreg << 1;
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == CNW'(1))
                  state <= UPDATE;
            end
            UPDATE: begin
               bcd_out     <= acc;
               led_balance <= snap_bal;
               led_equal   <= snap_eq;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [SW-1:0]     scan_cnt;
   logic [IW-1:0]     idx;
   logic [3:0]        cur_dig;
   logic              cur_blank;
   logic [DIGITS-1:0] an_nxt;
   logic [DIGITS-1:0] blank;
   logic [6:0]        seg_nxt;

`ifdef LEADING_ZERO_BLANK_EN
   logic zero_above;

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above && (bcd_out[4*k +: 4] == 4'd0);
         blank[k]   = zero_above;
      end
   end
`else
   always_comb begin
      blank = '0;
   end
`endif

   always_comb begin
      cur_dig   = 4'd0;
      cur_blank = 1'b0;
      an_nxt    = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_dig   = bcd_out[4*k +: 4];
            cur_blank = blank[k];
            an_nxt[k] = 1'b0;
         end
      end
   end

   always_comb begin
      seg_nxt = 7'b1111111;
      if (!cur_blank) begin
         case (cur_dig)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b1111111;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= '1;
         seg      <= 7'h7F;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_display_driver.sv
// Randomized self-checking bench for result_display_driver.
// Reference: decimal arithmetic on the driven value, scan position from cycle count.
module tb_result_display_driver;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;
   localparam int SCAN   = 4;

   logic                Clk = 1'b0;
   logic                reset;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;
   logic                led_balance;
   logic                led_equal;
   logic [4*DIGITS-1:0] bcd_out;
   logic                busy;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     scan_n   = 0;
   longint cur_v    = 0;
   logic   cur_b    = 1'b0;
   logic   cur_e    = 1'b0;

   result_display_driver_if #(.WIDTH(WIDTH)) alu_if ();

   result_display_driver #(
      .WIDTH   (WIDTH),
      .DIGITS  (DIGITS),
      .SCAN_DIV(SCAN)
   ) dut (
      .Clk        (Clk),
      .reset      (reset),
      .alu        (alu_if),
      .seg        (seg),
      .an         (an),
      .led_balance(led_balance),
      .led_equal  (led_equal),
      .bcd_out    (bcd_out),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   // clock edges since reset was last released
   always @(posedge Clk) begin
      if (reset) scan_n <= 0;
      else       scan_n <= scan_n + 1;
   end

   function automatic logic [4*DIGITS-1:0] to_bcd(longint v);
      logic [4*DIGITS-1:0] r;
      longint x;
      r = '0;
      x = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_code(int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] seg_at(longint v, int k);
      longint p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) return 7'b1111111;
`endif
      return seg_code(int'((v / p) % 10));
   endfunction

   task automatic step();
      @(negedge Clk);
   endtask

   task automatic drive(longint v, logic b, logic e);
      alu_if.output_num  = v[31:0];
      alu_if.balanceBit  = b;
      alu_if.equalityBit = e;
      cur_v = v;
      cur_b = b;
      cur_e = e;
   endtask

   task automatic check_display(longint v, int n);
      int idx;
      logic [DIGITS-1:0] exp_an;
      for (int i = 0; i < n; i++) begin
         step();
         idx = ((scan_n - 1) / SCAN) % DIGITS;
         exp_an = '1;
         exp_an[idx] = 1'b0;
         n_checks++;
         if (an !== exp_an || seg !== seg_at(v, idx)) begin
            n_fail++;
            $display("FAIL display v=%0d pos=%0d: an=%b seg=%b, required an=%b seg=%b",
                     v, idx, an, seg, exp_an, seg_at(v, idx));
         end
         n_checks++;
         if (busy !== 1'b0 || bcd_out !== to_bcd(v)) begin
            n_fail++;
            $display("FAIL idle_hold v=%0d: busy=%b bcd=%h, required busy=0 bcd=%h",
                     v, busy, bcd_out, to_bcd(v));
         end
      end
   endtask

   task automatic wait_conversion(output int cycles);
      cycles = 0;
      step();
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         step();
      end
   endtask

   task automatic check_result(string name, int cycles, longint v, logic b, logic e);
      n_checks++;
      if (cycles != WIDTH + 1) begin
         n_fail++;
         $display("FAIL %s latency: busy cycles=%0d, required %0d", name, cycles, WIDTH + 1);
      end
      n_checks++;
      if (bcd_out !== to_bcd(v) || led_balance !== b || led_equal !== e) begin
         n_fail++;
         $display("FAIL %s result: bcd=%h bal=%b eq=%b, required bcd=%h bal=%b eq=%b",
                  name, bcd_out, led_balance, led_equal, to_bcd(v), b, e);
      end
   endtask

   task automatic test_value(string name, longint v, logic b, logic e);
      int c;
      drive(v, b, e);
      wait_conversion(c);
      check_result(name, c, v, b, e);
      check_display(v, 44);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 1'b0, 1'b0);
      repeat (3) step();
      n_checks++;
      if (an !== '1 || seg !== 7'h7F || busy !== 1'b0 || bcd_out !== '0 ||
          led_balance !== 1'b0 || led_equal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: an=%b seg=%b busy=%b bcd=%h leds=%b%b, required all-ones 7f 0 0 00",
                  an, seg, busy, bcd_out, led_balance, led_equal);
      end
      reset = 1'b0;
      check_display(0, 48);
   endtask

   task automatic test_basic();
      test_value("dec1234", 1234, 1'b1, 1'b0);
      test_value("allones", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
      test_value("alldigits", 1234567890, 1'b1, 1'b1);
      test_value("forty", 40, 1'b0, 1'b0);
      test_value("zero_flag", 0, 1'b0, 1'b1);
   endtask

   task automatic test_no_change();
      drive(cur_v, cur_b, cur_e);
      check_display(cur_v, 40);
   endtask

   task automatic test_flags_only();
      test_value("flag_bal", cur_v, ~cur_b, cur_e);
      test_value("flag_eq", cur_v, cur_b, ~cur_e);
   endtask

   task automatic test_random();
      longint v;
      logic b, e;
      for (int i = 0; i < 8; i++) begin
         v = ($urandom % 2 == 0) ? longint'($urandom) : longint'($urandom_range(0, 99999));
         b = 1'($urandom);
         e = 1'($urandom);
         if (v == cur_v && b == cur_b && e == cur_e) v = v ^ 1;
         test_value("random", v, b, e);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      drive(5, 1'b0, 1'b0);
      c = 0;
      step();
      while (busy === 1'b1 && c < 200) begin
         c++;
         if (c == 10) alu_if.output_num = 32'd7;
         step();
      end
      check_result("b2b_first", c, 5, 1'b0, 1'b0);
      step();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: busy=%b one cycle after first result, required 1", busy);
      end
      c = 1;
      step();
      while (busy === 1'b1 && c < 200) begin
         c++;
         step();
      end
      cur_v = 7;
      check_result("b2b_second", c, 7, 1'b0, 1'b0);
      check_display(7, 20);
   endtask

   task automatic test_reset_mid();
      int c;
      drive(99, 1'b1, 1'b0);
      c = 0;
      step();
      while (busy === 1'b1 && c < 20) begin
         c++;
         step();
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (bcd_out !== '0 || busy !== 1'b0 || an !== '1 || seg !== 7'h7F ||
          led_balance !== 1'b0 || led_equal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: bcd=%h busy=%b an=%b seg=%b leds=%b%b, required 0 0 all-ones 7f 00",
                  bcd_out, busy, an, seg, led_balance, led_equal);
      end
      step();
      reset = 1'b0;
      wait_conversion(c);
      check_result("reconvert99", c, 99, 1'b1, 1'b0);
      check_display(99, 44);
   endtask

   initial begin
      reset = 1'b1;
      alu_if.output_num  = '0;
      alu_if.balanceBit  = 1'b0;
      alu_if.equalityBit = 1'b0;
      step();
      test_reset();
      test_basic();
      test_no_change();
      test_flags_only();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
